tcdm_responder: RTL

- Single-bank TCDM slave model that answers the TCDM requests issued by the accelerator's load/store streamer ports; it is the responder end of the TCDM protocol.
- Arbitrates NB_PORTS master ports round-robin, grants at most one request per cycle, and performs byte-masked writes and fixed-latency reads on an internal word array.
- Used in the accelerator testbench and as a scratch memory in standalone integration; its ports are the flattened slave side of the TCDM interface.

---
 rtl/tcdm_responder.sv | 105 ++++++++++
 1 files changed

// File: rtl/tcdm_responder.sv
// tcdm_responder: single-bank TCDM slave with round-robin grant, byte-masked writes and fixed-latency responses
// Ports: clk_i/rst_i clock and async active-high reset; tcdm_req_i/add_i/wen_i/be_i/data_i per-port request;
// tcdm_gnt_o combinational one-hot grant; tcdm_r_data_o/r_valid_o per-port response; stall_i per-port grant mask;
// oob_o sticky out-of-range flag; n_trans_o saturating granted-transaction count.
module tcdm_responder #(
    parameter int NB_PORTS     = 3,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int MEM_WORDS    = 1024,
    parameter int RESP_LATENCY = 1
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [NB_PORTS-1:0]                  tcdm_req_i,
    output logic [NB_PORTS-1:0]                  tcdm_gnt_o,
    input  logic [NB_PORTS-1:0][ADDR_WIDTH-1:0]  tcdm_add_i,
    input  logic [NB_PORTS-1:0]                  tcdm_wen_i,
    input  logic [NB_PORTS-1:0][DATA_WIDTH/8-1:0] tcdm_be_i,
    input  logic [NB_PORTS-1:0][DATA_WIDTH-1:0]  tcdm_data_i,
    output logic [NB_PORTS-1:0][DATA_WIDTH-1:0]  tcdm_r_data_o,
    output logic [NB_PORTS-1:0]                  tcdm_r_valid_o,
    input  logic [NB_PORTS-1:0]                  stall_i,
    output logic                                 oob_o,
    output logic [31:0]                          n_trans_o
);
    localparam int PW = NB_PORTS > 1 ? $clog2(NB_PORTS) : 1;
    localparam int IW = $clog2(MEM_WORDS);
    localparam int BW = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];
    logic [NB_PORTS-1:0]   elig;
    logic [PW-1:0]         ptr, sel;
    logic                  found;
    logic [ADDR_WIDTH-1:0] sel_add;
    logic [IW-1:0]         widx;
    logic                  oob_hit;
    logic [RESP_LATENCY-1:0] pv;
    logic [PW-1:0]         pid [RESP_LATENCY];
    logic [DATA_WIDTH-1:0] pd  [RESP_LATENCY];

    assign elig = tcdm_req_i & ~stall_i & {NB_PORTS{~rst_i}};

    // Lower-index ports below ptr are taken only if nothing at or above ptr is eligible.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int k = NB_PORTS - 1; k >= 0; k--)
            if (elig[k] && PW'(k) < ptr) begin
                found = 1'b1;
                sel   = PW'(k);
            end
        for (int k = NB_PORTS - 1; k >= 0; k--)
            if (elig[k] && PW'(k) >= ptr) begin
                found = 1'b1;
                sel   = PW'(k);
            end
    end

    assign tcdm_gnt_o = found ? (NB_PORTS'(1) << sel) : '0;
    assign sel_add    = tcdm_add_i[sel];
    assign widx       = sel_add[IW+1:2];
    assign oob_hit    = |(sel_add >> (IW + 2));

    always_ff @(posedge clk_i)
        if (found && !tcdm_wen_i[sel])
            for (int b = 0; b < BW; b++)
                if (tcdm_be_i[sel][b])
                    mem[widx][8*b +: 8] <= tcdm_data_i[sel][8*b +: 8];

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            pv        <= '0;
            ptr       <= '0;
            oob_o     <= 1'b0;
            n_trans_o <= '0;
            for (int s = 0; s < RESP_LATENCY; s++) begin
                pid[s] <= '0;
                pd[s]  <= '0;
            end
        end else begin
            pv[0]  <= found;
            pid[0] <= sel;
            pd[0]  <= (found && tcdm_wen_i[sel]) ? mem[widx] : '0;
            for (int s = 1; s < RESP_LATENCY; s++) begin
                pv[s]  <= pv[s-1];
                pid[s] <= pid[s-1];
                pd[s]  <= pd[s-1];
            end
            if (found && oob_hit)
                oob_o <= 1'b1;
            if (found && n_trans_o != '1)
                n_trans_o <= n_trans_o + 32'd1;
            if (found)
                ptr <= (sel == PW'(NB_PORTS - 1)) ? '0 : sel + PW'(1);
        end

    always_comb begin
        tcdm_r_valid_o = '0;
        tcdm_r_data_o  = '0;
        if (pv[RESP_LATENCY-1]) begin
            tcdm_r_valid_o[pid[RESP_LATENCY-1]] = 1'b1;
            tcdm_r_data_o[pid[RESP_LATENCY-1]]  = pd[RESP_LATENCY-1];
        end
    end
endmodule
